disp_mux_n: RTL and testbench
=============================

Name: disp_mux_n

Overview:
- Parametrised successor to the two-input text/game display multiplexer.
- Selects one of CH cycle-aligned VGA pipeline streams for the output stage.
- Channel changes are committed only at frame boundaries, with an optional per-frame brightness fade-out/fade-in, so switches never tear or glitch sync.
- Sits between the drawing pipelines and the final pclk output register stage.

Parameters:
- CH, 4: number of input streams (2..8).
- SEL_W, 3: width of sel_in; matches the game_state bus.
- INIT_CH, 0: active channel after reset.
- FADE_STEP, 1: frames per brightness level; 0 means an instant switch at vblank.

Ports:
- clk  in  1  pixel clock (pclk domain).
- rst  in  1  asynchronous, active-low reset.
- sel_in  in  SEL_W  requested channel; values >= CH are ignored.
- rgb_in  in  CH*12  packed rgb; channel k is at [12k+11:12k].
- hcount_in  in  CH*11  packed hcount.
- vcount_in  in  CH*11  packed vcount.
- hsync_in  in  CH  per-channel hsync.
- vsync_in  in  CH  per-channel vsync.
- hblnk_in  in  CH  per-channel hblnk.
- vblnk_in  in  CH  per-channel vblnk.
- rgb_out  out  12  {r,g,b} nibbles; registered.
- hcount_out  out  11  registered.
- vcount_out  out  11  registered.
- hsync_out  out  1  registered.
- vsync_out  out  1  registered.
- hblnk_out  out  1  registered.
- vblnk_out  out  1  registered.
- active_ch  out  3  channel currently driving the outputs.
- busy  out  1  high while a switch is pending or fading.

Behaviour:
- All inputs must be cycle-aligned; aligning them is the upstream pipelines' responsibility.
- Reset (rst=0, async):
  - all data and timing outputs 0;
  - active_ch=INIT_CH, pending=INIT_CH;
  - fade level fl=0, frame counter fc=0;
  - state=SHOW, busy=0.
- Datapath, 1-cycle latency:
  - every timing output is the active channel's input registered once;
  - rgb_out = 0 if that channel's hblnk or vblnk is 1;
  - otherwise each nibble of the active channel's rgb is shifted right by fl; fl=4 gives 0.
- Frame event fe: rising edge of vblnk_in[active_ch], detected against a registered copy of it.
- States:
  - SHOW, busy=0. If sel_in < CH and sel_in != active_ch: pending<=sel_in, fc<=0, then go to FADE_OUT (FADE_STEP>0) or WAIT_VB (FADE_STEP=0).
  - WAIT_VB: on fe, active_ch<=pending, go to SHOW.
  - FADE_OUT:
    - a valid sel_in different from pending overwrites pending; the fade is not restarted;
    - on fe: if fc==FADE_STEP-1 then fc<=0 and fl<=fl+1, else fc<=fc+1;
    - when the increment takes fl to 4: on that same fe, active_ch<=pending, go to FADE_IN.
  - FADE_IN:
    - sel_in is ignored;
    - fl decrements on fe with the same fc rule;
    - when fl reaches 0, go to SHOW;
    - a still-differing sel_in re-triggers from SHOW on the next cycle.
- Switch timing: the new active_ch takes effect for the datapath on the cycle after the fe that commits it. The swap happens inside vblank, so timing outputs change with no visible glitch.
- Sel returning to the current channel during FADE_OUT: the fade completes and swaps to that same channel; the sequence stays deterministic.
- Counter widths: fc is 8 bits, so FADE_STEP <= 255; fl is 3 bits, range 0..4.
- Reset asserted mid-fade returns immediately to the reset state; no partial fade persists.

Test Plan:
1. Assert rst=0 mid-line with all channels active → the next sampled outputs are all 0, active_ch=0, busy=0. Release rst → channel 0 passes through after 1 cycle.
2. Pass-through, FADE_STEP=1, channel 0:
   - rgb_in ch0=12'hABC, blanks 0 → rgb_out=12'hABC one cycle later;
   - hblnk ch0=1 → rgb_out=0;
   - hcount_out tracks ch0 hcount delayed by 1.
3. FADE_STEP=1, ch0 and ch1 drive 12'hFFF, sel_in 0→1:
   - busy=1 immediately;
   - on successive fe, rgb_out: 777, 333, 111, 000; the swap to ch1 happens at the 4th fe;
   - then 111, 333, 777, FFF;
   - busy=0 after the 8th fe; active_ch=1.
4. FADE_STEP=0, sel_in 0→2 mid-frame:
   - outputs stay on ch0 until vblnk ch0 rises;
   - next cycle hsync_out/rgb_out follow ch2 with no fade;
   - busy pulses from request until the swap.
5. CH=4, sel_in=5 → ignored: busy=0, active_ch unchanged for 3 frames.
6. FADE_STEP=2, sel_in 0→1, then 1→2 after the 3rd fe of FADE_OUT:
   - fade is not restarted; swap to ch2 at fe #8;
   - FADE_IN completes at fe #16; active_ch=2.

Source files
------------

// File: rtl/disp_mux_n.sv
// Frame-synchronous N-way VGA stream multiplexer with optional per-frame brightness fade.
// Channel switches are committed only on the active channel's vblank rising edge.
module disp_mux_n #(
    parameter int CH        = 4,
    parameter int SEL_W     = 3,
    parameter int INIT_CH   = 0,
    parameter int FADE_STEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SEL_W-1:0]  sel_in,
    input  logic [CH*12-1:0]  rgb_in,
    input  logic [CH*11-1:0]  hcount_in,
    input  logic [CH*11-1:0]  vcount_in,
    input  logic [CH-1:0]     hsync_in,
    input  logic [CH-1:0]     vsync_in,
    input  logic [CH-1:0]     hblnk_in,
    input  logic [CH-1:0]     vblnk_in,
    output logic [11:0]       rgb_out,
    output logic [10:0]       hcount_out,
    output logic [10:0]       vcount_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              hblnk_out,
    output logic              vblnk_out,
    output logic [2:0]        active_ch,
    output logic              busy
);

    typedef enum logic [1:0] {SHOW, WAIT_VB, FADE_OUT, FADE_IN} state_t;

    localparam logic [7:0] FC_LAST  = 8'((FADE_STEP > 0) ? FADE_STEP - 1 : 0);
    localparam logic [2:0] INIT_SEL = 3'(INIT_CH);

    state_t      state, state_nxt;
    logic [2:0]  pending, pending_nxt, active_nxt;
    logic [2:0]  fl, fl_nxt;
    logic [7:0]  fc, fc_nxt;

    logic [11:0] rgb_a, rgb_dim;
    logic [10:0] hc_a, vc_a;
    logic        hs_a, vs_a, hb_a, vb_a;
    logic        fe, sel_ok;
    logic [2:0]  sel_ch;

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        rgb_a = rgb_in[11:0];
        hc_a  = hcount_in[10:0];
        vc_a  = vcount_in[10:0];
        hs_a  = hsync_in[0];
        vs_a  = vsync_in[0];
        hb_a  = hblnk_in[0];
        vb_a  = vblnk_in[0];
        for (int k = 1; k < CH; k++) begin
            if (active_ch == 3'(k)) begin
                rgb_a = rgb_in[12*k +: 12];
                hc_a  = hcount_in[11*k +: 11];
                vc_a  = vcount_in[11*k +: 11];
                hs_a  = hsync_in[k];
                vs_a  = vsync_in[k];
                hb_a  = hblnk_in[k];
                vb_a  = vblnk_in[k];
            end
        end
    end

    // vblnk_out already holds last cycle's vblnk of the active channel.
    assign fe      = vb_a & ~vblnk_out;
    assign sel_ok  = (32'(sel_in) < 32'(CH));
    assign sel_ch  = 3'(sel_in);
    assign rgb_dim = {rgb_a[11:8] >> fl, rgb_a[7:4] >> fl, rgb_a[3:0] >> fl};
    assign busy    = (state != SHOW);

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        active_nxt  = active_ch;
        fl_nxt      = fl;
        fc_nxt      = fc;
        case (state)
            SHOW: begin
                if (sel_ok && sel_ch != active_ch) begin
                    pending_nxt = sel_ch;
                    fc_nxt      = 8'd0;
                    state_nxt   = (FADE_STEP > 0) ? FADE_OUT : WAIT_VB;
                end
            end
            WAIT_VB: begin
                if (fe) begin
                    active_nxt = pending;
                    state_nxt  = SHOW;
                end
            end
            FADE_OUT: begin
                if (sel_ok && sel_ch != pending)
                    pending_nxt = sel_ch;
                if (fe) begin
                    if (fc == FC_LAST) begin
                        fc_nxt = 8'd0;
                        fl_nxt = fl + 3'd1;
                        // Fully dark: swap to the latest request on this same frame event.
                        if (fl == 3'd3) begin
                            active_nxt = pending_nxt;
                            state_nxt  = FADE_IN;
                        end
                    end else begin
                        fc_nxt = fc + 8'd1;
                    end
                end
            end
            FADE_IN: begin
                if (fe) begin
                    if (fc == FC_LAST) begin
                        fc_nxt = 8'd0;
                        fl_nxt = fl - 3'd1;
                        if (fl == 3'd1)
                            state_nxt = SHOW;
                    end else begin
                        fc_nxt = fc + 8'd1;
                    end
                end
            end
            default: state_nxt = SHOW;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= SHOW;
            active_ch <= INIT_SEL;
            pending   <= INIT_SEL;
            fl        <= 3'd0;
            fc        <= 8'd0;
        end else begin
            state     <= state_nxt;
            active_ch <= active_nxt;
            pending   <= pending_nxt;
            fl        <= fl_nxt;
            fc        <= fc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb_out    <= 12'd0;
            hcount_out <= 11'd0;
            vcount_out <= 11'd0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
        end else begin
            rgb_out    <= (hb_a || vb_a) ? 12'd0 : rgb_dim;
            hcount_out <= hc_a;
            vcount_out <= vc_a;
            hsync_out  <= hs_a;
            vsync_out  <= vs_a;
            hblnk_out  <= hb_a;
            vblnk_out  <= vb_a;
        end
    end

endmodule

// File: tb/tb_disp_mux_n.sv
// Bench for disp_mux_n: three instances (FADE_STEP 1, 0, 2) share one synthetic 16x8 video
// source and are compared each cycle against a frame-event-counting reference model.
module tb_disp_mux_n;

    localparam int CH = 4;
    localparam int NI = 3;
    localparam int HT = 16;
    localparam int VT = 8;

    int steps[NI] = '{1, 0, 2};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]    sel_in;
    logic [CH*12-1:0] rgb_in;
    logic [CH*11-1:0] hcount_in, vcount_in;
    logic [CH-1:0] hsync_in, vsync_in, hblnk_in, vblnk_in;

    logic [11:0] rgb_o[NI];
    logic [10:0] hc_o[NI], vc_o[NI];
    logic        hs_o[NI], vs_o[NI], hb_o[NI], vb_o[NI];
    logic [2:0]  act_o[NI];
    logic        busy_o[NI];

    disp_mux_n #(.CH(CH), .SEL_W(3), .INIT_CH(0), .FADE_STEP(1)) u0 (
        .clk(clk), .rst(rst), .sel_in(sel_in), .rgb_in(rgb_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_out(rgb_o[0]), .hcount_out(hc_o[0]),
        .vcount_out(vc_o[0]), .hsync_out(hs_o[0]), .vsync_out(vs_o[0]), .hblnk_out(hb_o[0]),
        .vblnk_out(vb_o[0]), .active_ch(act_o[0]), .busy(busy_o[0]));

    disp_mux_n #(.CH(CH), .SEL_W(3), .INIT_CH(0), .FADE_STEP(0)) u1 (
        .clk(clk), .rst(rst), .sel_in(sel_in), .rgb_in(rgb_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_out(rgb_o[1]), .hcount_out(hc_o[1]),
        .vcount_out(vc_o[1]), .hsync_out(hs_o[1]), .vsync_out(vs_o[1]), .hblnk_out(hb_o[1]),
        .vblnk_out(vb_o[1]), .active_ch(act_o[1]), .busy(busy_o[1]));

    disp_mux_n #(.CH(CH), .SEL_W(3), .INIT_CH(0), .FADE_STEP(2)) u2 (
        .clk(clk), .rst(rst), .sel_in(sel_in), .rgb_in(rgb_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_out(rgb_o[2]), .hcount_out(hc_o[2]),
        .vcount_out(vc_o[2]), .hsync_out(hs_o[2]), .vsync_out(vs_o[2]), .hblnk_out(hb_o[2]),
        .vblnk_out(vb_o[2]), .active_ch(act_o[2]), .busy(busy_o[2]));

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Video source state
    int hc = 0, vc = 0, last_hc = 0, last_vc = 0, frames = 0;
    int rgb_mode = 0;
    bit rand_sel = 1'b0;

    task automatic drive();
        for (int k = 0; k < CH; k++) begin
            hcount_in[11*k +: 11] = 11'(hc) | 11'(k << 8);
            vcount_in[11*k +: 11] = 11'(vc) | 11'(k << 8);
            hblnk_in[k] = (hc >= 12);
            vblnk_in[k] = (vc >= 6);
            hsync_in[k] = ((hc == 13) || (hc == 14)) ^ (k % 2 == 1);
            vsync_in[k] = (vc == 7) ^ (k >= 2);
            case (rgb_mode)
                1:       rgb_in[12*k +: 12] = 12'hFFF;
                2:       rgb_in[12*k +: 12] = (k == 0) ? 12'hABC : 12'($urandom);
                default: rgb_in[12*k +: 12] = 12'($urandom);
            endcase
        end
    endtask

    // Reference model: a switch is a count of frame events n; brightness follows from n.
    int       m_act[NI], m_pend[NI], m_n[NI];
    bit       m_sw[NI];
    logic     m_vbq[NI];
    logic [63:0] m_vec[NI];

    function automatic int level(int n, int s);
        return (n < 4*s) ? n / s : 4 - (n - 4*s) / s;
    endfunction

    function automatic logic [11:0] dim(logic [11:0] c, int l);
        return {c[11:8] >> l, c[7:4] >> l, c[3:0] >> l};
    endfunction

    function automatic logic [63:0] dut_vec(int i);
        return {22'd0, rgb_o[i], hc_o[i], vc_o[i], hs_o[i], vs_o[i], hb_o[i], vb_o[i],
                act_o[i], busy_o[i]};
    endfunction

    task automatic model_reset(int i);
        m_act[i] = 0; m_pend[i] = 0; m_n[i] = 0; m_sw[i] = 1'b0;
        m_vbq[i] = 1'b0; m_vec[i] = 64'd0;
    endtask

    task automatic model_step(int i);
        int a, s, lvl, sel;
        bit fe, valid;
        logic vb;
        logic [11:0] rgb;
        a     = m_act[i];
        s     = steps[i];
        sel   = int'(sel_in);
        valid = (sel < CH);
        vb    = vblnk_in[a];
        fe    = vb && !m_vbq[i];
        lvl   = (m_sw[i] && s > 0) ? level(m_n[i], s) : 0;
        rgb   = (hblnk_in[a] || vb) ? 12'd0 : dim(rgb_in[12*a +: 12], lvl);
        m_vec[i][63:1] = {22'd0, rgb, hcount_in[11*a +: 11], vcount_in[11*a +: 11],
                          hsync_in[a], vsync_in[a], hblnk_in[a], vb, 3'd0};
        m_vbq[i] = vb;
        if (!m_sw[i]) begin
            if (valid && sel != m_act[i]) begin
                m_pend[i] = sel; m_sw[i] = 1'b1; m_n[i] = 0;
            end
        end else if (s == 0) begin
            if (fe) begin
                m_act[i] = m_pend[i]; m_sw[i] = 1'b0;
            end
        end else if (m_n[i] < 4*s) begin
            if (valid && sel != m_pend[i]) m_pend[i] = sel;
            if (fe) begin
                m_n[i]++;
                if (m_n[i] == 4*s) m_act[i] = m_pend[i];
            end
        end else if (fe) begin
            m_n[i]++;
            if (m_n[i] == 8*s) m_sw[i] = 1'b0;
        end
        m_vec[i][3:0] = {3'(m_act[i]), m_sw[i]};
    endtask

    task automatic step();
        @(posedge clk);
        if (rst)
            for (int i = 0; i < NI; i++) model_step(i);
        last_hc = hc;
        last_vc = vc;
        if (hc == 0 && vc == 6) frames++;
        #1;
        for (int i = 0; i < NI; i++) check($sformatf("model_inst%0d", i), dut_vec(i), m_vec[i]);
        @(negedge clk);
        hc = (hc + 1) % HT;
        if (hc == 0) vc = (vc + 1) % VT;
        if (rand_sel && $urandom_range(0, 149) == 0) sel_in = 3'($urandom_range(0, 7));
        drive();
    endtask

    task automatic run_to(int h, int v);
        int guard = 0;
        do begin
            step();
            guard++;
        end while (!(last_hc == h && last_vc == v) && guard < 2*HT*VT);
        if (guard >= 2*HT*VT) begin
            checks++; errors++;
            $display("FAIL run_to timeout got=%0d,%0d exp=%0d,%0d", last_hc, last_vc, h, v);
        end
    endtask

    task automatic wait_frames(int n);
        int target = frames + n;
        int guard = 0;
        while (frames < target && guard < n*HT*VT + HT*VT) begin
            step();
            guard++;
        end
        if (frames < target) begin
            checks++; errors++;
            $display("FAIL wait_frames timeout got=%0d exp=%0d", frames, target);
        end
    endtask

    // Async assertion between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset_inst%0d", i), dut_vec(i), 64'd0);
            model_reset(i);
        end
        step();
        step();
        rst = 1'b1;
    endtask

    logic [11:0] fade_tab[8] = '{12'h777, 12'h333, 12'h111, 12'h000,
                                 12'h111, 12'h333, 12'h777, 12'hFFF};

    initial begin
        sel_in = 3'd0;
        drive();
        for (int i = 0; i < NI; i++) model_reset(i);
        #1 rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;

        // Reset mid-line while all channels carry active video
        wait_frames(1);
        run_to(5, 2);
        do_reset();

        // Pass-through on channel 0
        rgb_mode = 2;
        run_to(3, 4);
        check("pass_rgb", 64'(rgb_o[0]), 64'hABC);
        check("pass_hcount", 64'(hc_o[0]), 64'(last_hc));
        run_to(12, 4);
        check("hblnk_rgb", 64'(rgb_o[0]), 64'h0);

        // Fade 0 -> 1 on full white, FADE_STEP=1
        rgb_mode = 1;
        run_to(0, 1);
        sel_in = 3'd1;
        step();
        check("fade_busy_now", 64'(busy_o[0]), 64'd1);
        for (int k = 0; k < 8; k++) begin
            run_to(2, 0);
            check($sformatf("fade_rgb%0d", k), 64'(rgb_o[0]), 64'(fade_tab[k]));
            if (k == 3) check("fade_swap_ch", 64'(act_o[0]), 64'd1);
        end
        check("fade_done_busy", 64'(busy_o[0]), 64'd0);
        check("fade_done_ch", 64'(act_o[0]), 64'd1);

        // Instant switch 0 -> 2, FADE_STEP=0
        rgb_mode = 0;
        sel_in = 3'd0;
        run_to(5, 2);
        do_reset();
        run_to(4, 2);
        sel_in = 3'd2;
        step();
        check("inst_busy", 64'(busy_o[1]), 64'd1);
        run_to(15, 5);
        check("inst_hold_vc", 64'(vc_o[1]), 64'd5);
        check("inst_hold_ch", 64'(act_o[1]), 64'd0);
        run_to(0, 6);
        check("inst_swap_ch", 64'(act_o[1]), 64'd2);
        check("inst_swap_busy", 64'(busy_o[1]), 64'd0);
        step();
        check("inst_new_vc", 64'(vc_o[1]), 64'h206);

        // Out-of-range select is ignored
        sel_in = 3'd0;
        run_to(5, 2);
        do_reset();
        sel_in = 3'd5;
        wait_frames(3);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("ign_busy%0d", i), 64'(busy_o[i]), 64'd0);
            check($sformatf("ign_ch%0d", i), 64'(act_o[i]), 64'd0);
        end

        // FADE_STEP=2: retarget 1 -> 2 after the third frame event, no restart
        sel_in = 3'd0;
        run_to(5, 2);
        do_reset();
        run_to(0, 1);
        sel_in = 3'd1;
        wait_frames(3);
        sel_in = 3'd2;
        wait_frames(4);
        check("s2_fe7_ch", 64'(act_o[2]), 64'd0);
        wait_frames(1);
        check("s2_fe8_ch", 64'(act_o[2]), 64'd2);
        wait_frames(7);
        check("s2_fe15_busy", 64'(busy_o[2]), 64'd1);
        wait_frames(1);
        check("s2_fe16_busy", 64'(busy_o[2]), 64'd0);
        check("s2_fe16_ch", 64'(act_o[2]), 64'd2);

        // Reset mid-fade, then random selection traffic
        sel_in = 3'd3;
        wait_frames(2);
        run_to(5, 2);
        do_reset();
        rand_sel = 1'b1;
        wait_frames(40);
        rand_sel = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
